// File: rtl/fifo_rr_ctrl_if.sv
// Bundle between fifo_rr_ctrl and its producers, sync_fifo and consumer.
// master = controller side; slave = producers, FIFO flags and consumer side.
interface fifo_rr_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = $clog2(DEPTH + 1);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               flush;
  logic               f_full;
  logic               f_empty;
  logic               wr_en;
  logic [DW-1:0]      data_in;
  logic [IW-1:0]      grant_id;
  logic               rd_en;
  logic               dout_valid;
  logic               burst_active;
  logic [LW-1:0]      level;

  modport master (
    input  req_valid, req_data, flush, f_full, f_empty,
    output req_ready, wr_en, data_in, grant_id, rd_en, dout_valid, burst_active, level
  );

  modport slave (
    output req_valid, req_data, flush, f_full, f_empty,
    input  req_ready, wr_en, data_in, grant_id, rd_en, dout_valid, burst_active, level
  );
endinterface

// File: rtl/fifo_rr_ctrl.sv
// Round-robin sharing of a sync_fifo write port plus burst read scheduling; wr_en lands 1 cycle
// after handshake, reads go out in runs of min(BURST, level); req_ready drops while the FIFO is full.
module fifo_rr_ctrl #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int DEPTH = 8,
  parameter int BURST = 4
) (
  input logic           clk,
  input logic           rst,
  fifo_rr_ctrl_if.master bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] L_DEPTH = LW'(DEPTH);
  localparam logic [LW-1:0] L_BURST = LW'(BURST);
  localparam logic [IW-1:0] PTR_RST = IW'(NREQ - 1);

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t          r_state, w_state_nxt;
  logic [IW-1:0]   r_ptr, w_win, w_idx;
  logic            w_gnt;
  logic [NREQ-1:0] w_ready;
  logic [LW-1:0]   r_level, w_level_nxt;
  logic [LW-1:0]   r_beats, w_beats_nxt;
  logic            w_rd;
  logic            r_wr_en, r_rd_en, r_dout_valid;
  logic [DW-1:0]   r_data_in;
  logic [IW-1:0]   r_grant_id;

  // Search starts just past the last winner so every requester gets a turn.
  always_comb begin
    w_gnt   = 1'b0;
    w_win   = r_ptr;
    w_idx   = r_ptr;
    w_ready = '0;
    if (r_level < L_DEPTH && !bus.f_full) begin
      for (int k = 1; k <= NREQ; k++) begin
        w_idx = IW'((int'(r_ptr) + k) % NREQ);
        if (!w_gnt && bus.req_valid[w_idx]) begin
          w_gnt = 1'b1;
          w_win = w_idx;
        end
      end
    end
    if (w_gnt) w_ready[w_win] = 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_beats_nxt = r_beats;
    w_rd        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_level >= L_BURST || (bus.flush && r_level != '0)) begin
          w_state_nxt = S_BURST;
          w_beats_nxt = (r_level >= L_BURST) ? L_BURST : r_level;
          w_rd        = !bus.f_empty;
          if (w_rd) w_beats_nxt = w_beats_nxt - LW'(1);
        end
      end
      S_BURST: begin
        // r_beats counts reads still owed after the one currently on rd_en.
        if (r_beats == '0) begin
          w_state_nxt = S_IDLE;
        end else if (r_level != '0 && !bus.f_empty) begin
          w_rd        = 1'b1;
          w_beats_nxt = r_beats - LW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_level_nxt = r_level;
    if (w_gnt && !w_rd)      w_level_nxt = r_level + LW'(1);
    else if (!w_gnt && w_rd) w_level_nxt = r_level - LW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_beats      <= '0;
      r_level      <= '0;
      r_ptr        <= PTR_RST;
      r_wr_en      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_dout_valid <= 1'b0;
      r_data_in    <= '0;
      r_grant_id   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_beats      <= w_beats_nxt;
      r_level      <= w_level_nxt;
      r_wr_en      <= w_gnt;
      r_rd_en      <= w_rd;
      r_dout_valid <= r_rd_en;
      if (w_gnt) begin
        r_ptr      <= w_win;
        r_grant_id <= w_win;
        r_data_in  <= bus.req_data[w_win*DW +: DW];
      end
    end
  end

  assign bus.req_ready    = w_ready;
  assign bus.wr_en        = r_wr_en;
  assign bus.data_in      = r_data_in;
  assign bus.grant_id     = r_grant_id;
  assign bus.rd_en        = r_rd_en;
  assign bus.dout_valid   = r_dout_valid;
  assign bus.burst_active = (r_state == S_BURST);
  assign bus.level        = r_level;
endmodule

// File: tb/tb_fifo_rr_ctrl.sv
// Bench for fifo_rr_ctrl: BURST=4 instance with a behavioural sync_fifo and a queue scoreboard,
// plus a BURST=DEPTH instance for the fill-to-full grant order.
module tb_fifo_rr_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  fifo_rr_ctrl_if #(.NREQ(4), .DW(8), .DEPTH(8)) bus_a ();
  fifo_rr_ctrl_if #(.NREQ(4), .DW(8), .DEPTH(8)) bus_b ();

  fifo_rr_ctrl #(.NREQ(4), .DW(8), .DEPTH(8), .BURST(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus_a)
  );
  fifo_rr_ctrl #(.NREQ(4), .DW(8), .DEPTH(8), .BURST(8)) u_dut8 (
    .clk(clk), .rst(rst), .bus(bus_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural sync_fifo: data_out appears the cycle after rd_en is sampled.
  logic [7:0] f_mem [8];
  int         f_cnt = 0, f_wp = 0, f_rp = 0;
  logic [7:0] f_dout = 8'h00;
  assign bus_a.f_full  = (f_cnt == 8);
  assign bus_a.f_empty = (f_cnt == 0);
  assign bus_b.f_full  = 1'b0;
  assign bus_b.f_empty = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      f_cnt <= 0;
      f_wp  <= 0;
      f_rp  <= 0;
    end else begin
      if (bus_a.rd_en && f_cnt != 0) begin
        f_dout <= f_mem[f_rp];
        f_rp   <= (f_rp + 1) % 8;
      end
      if (bus_a.wr_en && f_cnt != 8) begin
        f_mem[f_wp] <= bus_a.data_in;
        f_wp        <= (f_wp + 1) % 8;
      end
      f_cnt <= f_cnt + ((bus_a.wr_en && f_cnt != 8) ? 1 : 0) - ((bus_a.rd_en && f_cnt != 0) ? 1 : 0);
    end
  end

  logic [9:0] wq[$];
  logic [7:0] rq[$];
  logic [1:0] gq_b[$];

  // Reference arbiter: predicts the grant each cycle and queues the expected write and read.
  int         m_ptr = 3, m_lvl = 0, win;
  logic       m_g = 1'b0;
  logic [3:0] exp_rdy;
  logic [7:0] d;
  initial forever begin
    @(negedge clk);
    if (rst) begin
      m_ptr = 3;
      m_lvl = 0;
      m_g   = 1'b0;
      wq.delete();
      rq.delete();
    end else begin
      m_lvl = m_lvl + int'(m_g) - int'(bus_a.rd_en);
      chk("level_a", 32'(bus_a.level), 32'(m_lvl));
      win = -1;
      if (m_lvl < 8 && !bus_a.f_full)
        for (int k = 1; k <= 4; k++)
          if (win < 0 && bus_a.req_valid[(m_ptr + k) % 4]) win = (m_ptr + k) % 4;
      exp_rdy = (win >= 0) ? 4'(1 << win) : 4'b0000;
      chk("req_ready_a", 32'(bus_a.req_ready), 32'(exp_rdy));
      m_g = (win >= 0);
      if (m_g) begin
        d     = bus_a.req_data[win*8 +: 8];
        m_ptr = win;
        wq.push_back({2'(win), d});
        rq.push_back(d);
      end
    end
  end

  // Monitors: pop expected entries whenever the DUTs present a write or read beat.
  logic [9:0] wexp;
  logic [7:0] rexp;
  logic [1:0] gexp;
  initial forever begin
    @(posedge clk);
    #2;
    if (bus_a.wr_en === 1'b1) begin
      chk("wr_expected", 32'(wq.size() != 0), 32'd1);
      if (wq.size() != 0) begin
        wexp = wq.pop_front();
        chk("wr_id_data", 32'({bus_a.grant_id, bus_a.data_in}), 32'(wexp));
      end
    end
    if (bus_a.dout_valid === 1'b1) begin
      chk("rd_expected", 32'(rq.size() != 0), 32'd1);
      if (rq.size() != 0) begin
        rexp = rq.pop_front();
        chk("rd_data", 32'(f_dout), 32'(rexp));
      end
    end
    if (bus_b.wr_en === 1'b1) begin
      chk("b_wr_expected", 32'(gq_b.size() != 0), 32'd1);
      if (gq_b.size() != 0) begin
        gexp = gq_b.pop_front();
        chk("b_grant_id", 32'(bus_b.grant_id), 32'(gexp));
      end
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst             = 1'b1;
    bus_a.req_valid = 4'b0000;
    bus_a.flush     = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int          v, rdy_cnt, wr_cnt, rd_cnt, lvl5;
  logic [15:0] rd_tr;
  logic [19:0] gseq;
  logic        saw8;

  initial begin
    bus_a.req_valid = 4'b0000;
    bus_a.req_data  = 32'h0;
    bus_a.flush     = 1'b0;
    bus_b.req_valid = 4'b0000;
    bus_b.req_data  = 32'h0;
    bus_b.flush     = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    @(negedge clk);
    chk("rst_wr_en", 32'(bus_a.wr_en), 32'd0);
    chk("rst_rd_en", 32'(bus_a.rd_en), 32'd0);
    chk("rst_dout_valid", 32'(bus_a.dout_valid), 32'd0);
    chk("rst_burst_active", 32'(bus_a.burst_active), 32'd0);
    chk("rst_data_grant", 32'({bus_a.grant_id, bus_a.data_in}), 32'd0);

    // Fill-to-full with all four requesters and BURST = DEPTH.
    for (int i = 0; i < 8; i++) gq_b.push_back(2'(i % 4));
    saw8 = 1'b0;
    @(posedge clk);
    #1;
    bus_b.req_valid = 4'hF;
    for (int c = 0; c < 12 && !saw8; c++) begin
      @(negedge clk);
      if (bus_b.level == 4'd8) begin
        chk("b_full_no_ready", 32'(bus_b.req_ready), 32'd0);
        saw8            = 1'b1;
        bus_b.req_valid = 4'b0000;
      end
    end
    chk("b_reached_full", 32'(saw8), 32'd1);
    repeat (12) @(posedge clk);
    chk("b_all_grants_seen", 32'(gq_b.size()), 32'd0);

    // Requester 0 streams 0..7: two bursts of four with a one-cycle gap.
    v = 0; rdy_cnt = 0; wr_cnt = 0; rd_tr = 16'h0; lvl5 = 0;
    for (int c = 0; c < 16; c++) begin
      @(posedge clk);
      #1;
      bus_a.req_valid     = (v < 8) ? 4'b0001 : 4'b0000;
      bus_a.req_data[7:0] = 8'(v);
      @(negedge clk);
      rd_tr  = rd_tr | (16'(bus_a.rd_en) << c);
      wr_cnt = wr_cnt + int'(bus_a.wr_en);
      if (c == 5) lvl5 = int'(bus_a.level);
      if (bus_a.req_valid[0] && bus_a.req_ready[0]) begin
        rdy_cnt++;
        v++;
      end
    end
    chk("t1_ready_cycles", 32'(rdy_cnt), 32'd8);
    chk("t1_wr_cycles", 32'(wr_cnt), 32'd8);
    chk("t1_rd_pattern", 32'(rd_tr), 32'h3DE0);
    chk("t1_level_grant_and_read", 32'(lvl5), 32'd4);

    // Requesters 1 and 3 alternate once the pointer sits on 1.
    gseq = 20'h0;
    @(posedge clk);
    #1;
    bus_a.req_valid = 4'b0010;
    bus_a.req_data  = 32'h30201000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      gseq = {gseq[15:0], bus_a.req_ready};
      @(posedge clk);
      #1;
      bus_a.req_valid = 4'b1010;
      bus_a.req_data  = bus_a.req_data + 32'h01010101;
    end
    bus_a.req_valid = 4'b0000;
    chk("t3_rr_order", 32'(gseq), 32'h28282);
    repeat (15) @(posedge clk);

    // Three entries sit below BURST until a single flush pulse drains them.
    do_reset();
    for (int c = 0; c < 3; c++) begin
      bus_a.req_valid       = 4'b0100;
      bus_a.req_data[23:16] = 8'(8'hA0 + c);
      @(posedge clk);
      #1;
    end
    bus_a.req_valid = 4'b0000;
    rd_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      rd_cnt = rd_cnt + int'(bus_a.rd_en);
    end
    chk("t4_no_read_below_burst", 32'(rd_cnt), 32'd0);
    chk("t4_level_3", 32'(bus_a.level), 32'd3);
    @(posedge clk);
    #1;
    bus_a.flush = 1'b1;
    @(posedge clk);
    #1;
    bus_a.flush = 1'b0;
    rd_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      rd_cnt = rd_cnt + int'(bus_a.rd_en);
    end
    chk("t4_flush_beats", 32'(rd_cnt), 32'd3);
    chk("t4_level_0", 32'(bus_a.level), 32'd0);
    chk("t4_back_idle", 32'(bus_a.burst_active), 32'd0);

    // Random mix of requesters and flush, then drain and confirm nothing lost.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      bus_a.req_valid = 4'($urandom_range(0, 15));
      bus_a.req_data  = $urandom();
      bus_a.flush     = 1'($urandom_range(0, 1));
    end
    @(posedge clk);
    #1;
    bus_a.req_valid = 4'b0000;
    bus_a.flush     = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    bus_a.flush = 1'b0;
    @(negedge clk);
    chk("t5_writes_drained", 32'(wq.size()), 32'd0);
    chk("t5_reads_drained", 32'(rq.size()), 32'd0);
    chk("t5_level_0", 32'(bus_a.level), 32'd0);

    // Reset lands during the second beat of a burst.
    do_reset();
    bus_a.req_valid = 4'b0001;
    bus_a.req_data  = 32'h00000050;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("t6_second_beat", 32'(bus_a.rd_en), 32'd1);
    @(posedge clk);
    #1;
    rst             = 1'b0;
    bus_a.req_valid = 4'hF;
    bus_a.req_data  = 32'h63524170;
    @(negedge clk);
    chk("t6_rd_en", 32'(bus_a.rd_en), 32'd0);
    chk("t6_wr_en", 32'(bus_a.wr_en), 32'd0);
    chk("t6_burst_active", 32'(bus_a.burst_active), 32'd0);
    chk("t6_level", 32'(bus_a.level), 32'd0);
    chk("t6_first_winner", 32'(bus_a.req_ready), 32'd1);
    repeat (5) @(posedge clk);
    #1;
    bus_a.req_valid = 4'b0000;
    bus_a.flush     = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    bus_a.flush = 1'b0;
    @(negedge clk);
    chk("t6_writes_drained", 32'(wq.size()), 32'd0);
    chk("t6_reads_drained", 32'(rq.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
